// File: rtl/inst_loader.sv
// Boot loader: count byte, MSB-first words, XOR checksum -> instruction memory; holds processor in reset until a good load.
// Word write 1 cycle after its last byte; rx_ready depends only on state (never stalls mid-load).
module inst_loader #(
  parameter int INST_W = 32,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              sys_rst,
  input  logic              start,
  input  logic              rx_valid,
  input  logic [7:0]        rx_byte,
  output logic              rx_ready,
  output logic              im_we,
  output logic [ADDR_W-1:0] im_addr,
  output logic [INST_W-1:0] im_wdata,
  output logic              proc_rst,
  output logic              load_done,
  output logic              err,
  output logic [1:0]        err_code
);

  localparam int BYTES = INST_W / 8;
  localparam int BI_W  = (BYTES > 1) ? $clog2(BYTES) : 1;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    COUNT = 3'd1,
    DATA  = 3'd2,
    CHECK = 3'd3,
    DONE  = 3'd4,
    ERR   = 3'd5
  } state_t;

  state_t              state_q, state_d;
  logic [7:0]          cnt_q, cnt_d;
  logic [ADDR_W-1:0]   word_idx_q, word_idx_d;
  logic [BI_W-1:0]     byte_idx_q, byte_idx_d;
  logic [7:0]          xor_q, xor_d;
  logic [INST_W-1:0]   shift_q, shift_d;
  logic [1:0]          err_code_q, err_code_d;
  logic                im_we_q, im_we_d;
  logic [ADDR_W-1:0]   im_addr_q, im_addr_d;
  logic [INST_W-1:0]   im_wdata_q, im_wdata_d;
  logic                accept;
  logic [INST_W-1:0]   word_next;
  logic                last_byte;
  logic                last_word;

  always_ff @(posedge clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      word_idx_q <= '0;
      byte_idx_q <= '0;
      xor_q      <= '0;
      shift_q    <= '0;
      err_code_q <= '0;
      im_we_q    <= 1'b0;
      im_addr_q  <= '0;
      im_wdata_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      word_idx_q <= word_idx_d;
      byte_idx_q <= byte_idx_d;
      xor_q      <= xor_d;
      shift_q    <= shift_d;
      err_code_q <= err_code_d;
      im_we_q    <= im_we_d;
      im_addr_q  <= im_addr_d;
      im_wdata_q <= im_wdata_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    word_idx_d = word_idx_q;
    byte_idx_d = byte_idx_q;
    xor_d      = xor_q;
    shift_d    = shift_q;
    err_code_d = err_code_q;
    im_we_d    = 1'b0;
    im_addr_d  = im_addr_q;
    im_wdata_d = im_wdata_q;

    rx_ready  = (state_q == COUNT) || (state_q == DATA) || (state_q == CHECK);
    accept    = rx_valid && rx_ready;
    // Bytes arrive MSB first, so old bytes shift up and fall off the top.
    word_next = (shift_q << 8) | INST_W'(rx_byte);
    last_byte = (byte_idx_q == BI_W'(BYTES - 1));
    last_word = (int'(word_idx_q) == int'(cnt_q) - 1);

    case (state_q)
      IDLE, DONE, ERR: begin
        if (start) begin
          state_d    = COUNT;
          word_idx_d = '0;
          byte_idx_d = '0;
          xor_d      = '0;
          err_code_d = 2'b00;
        end
      end
      COUNT: begin
        if (accept) begin
          cnt_d = rx_byte;
          xor_d = xor_q ^ rx_byte;
          if ((rx_byte == 8'd0) || (int'(rx_byte) > DEPTH)) begin
            state_d    = ERR;
            err_code_d = 2'b01;
          end else begin
            state_d = DATA;
          end
        end
      end
      DATA: begin
        if (accept) begin
          xor_d   = xor_q ^ rx_byte;
          shift_d = word_next;
          if (last_byte) begin
            byte_idx_d = '0;
            im_we_d    = 1'b1;
            im_addr_d  = word_idx_q;
            im_wdata_d = word_next;
            // Index stays on the final word so it never reaches DEPTH.
            if (last_word) begin
              state_d = CHECK;
            end else begin
              word_idx_d = word_idx_q + ADDR_W'(1);
            end
          end else begin
            byte_idx_d = byte_idx_q + BI_W'(1);
          end
        end
      end
      CHECK: begin
        if (accept) begin
          if (rx_byte == xor_q) begin
            state_d = DONE;
          end else begin
            state_d    = ERR;
            err_code_d = 2'b10;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign im_we     = im_we_q;
  assign im_addr   = im_addr_q;
  assign im_wdata  = im_wdata_q;
  assign proc_rst  = (state_q != DONE);
  assign load_done = (state_q == DONE);
  assign err       = (state_q == ERR);
  assign err_code  = err_code_q;

endmodule

// File: tb/tb_inst_loader.sv
// Scoreboarded bench for inst_loader: expected writes queued by stimulus, popped by a write monitor.
module tb_inst_loader;
  localparam int INST_W = 32;
  localparam int DEPTH  = 16;
  localparam int ADDR_W = 4;

  logic              clk = 1'b0;
  logic              sys_rst = 1'b1;
  logic              start = 1'b0;
  logic              rx_valid = 1'b0;
  logic [7:0]        rx_byte = 8'h00;
  logic              rx_ready;
  logic              im_we;
  logic [ADDR_W-1:0] im_addr;
  logic [INST_W-1:0] im_wdata;
  logic              proc_rst;
  logic              load_done;
  logic              err;
  logic [1:0]        err_code;

  int tests = 0;
  int fails = 0;
  logic [ADDR_W+INST_W-1:0] exp_q[$];
  logic [INST_W-1:0]        words[DEPTH];

  inst_loader #(.INST_W(INST_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .sys_rst(sys_rst), .start(start),
    .rx_valid(rx_valid), .rx_byte(rx_byte), .rx_ready(rx_ready),
    .im_we(im_we), .im_addr(im_addr), .im_wdata(im_wdata),
    .proc_rst(proc_rst), .load_done(load_done), .err(err), .err_code(err_code)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Write monitor: every im_we cycle must match the oldest expected write.
  initial begin
    forever begin
      @(negedge clk);
      if (im_we) begin
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_write: got addr %0h data %0h expected no write", im_addr, im_wdata);
        end else begin
          logic [ADDR_W+INST_W-1:0] e;
          e = exp_q.pop_front();
          check("write_addr", 32'(im_addr), 32'(e[ADDR_W+INST_W-1:INST_W]));
          check("write_data", im_wdata, e[INST_W-1:0]);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic send_byte(input logic [7:0] b, input bit stall);
    int n;
    if (stall) begin
      int gaps;
      gaps = $urandom_range(0, 3);
      for (int g = 0; g < gaps; g++) begin
        rx_valid = 1'b0;
        rx_byte  = 8'($urandom);
        @(posedge clk); #1;
      end
    end
    rx_valid = 1'b1;
    rx_byte  = b;
    n = 0;
    while (!rx_ready && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    if (!rx_ready) begin
      tests++;
      fails++;
      $display("FAIL rx_ready_timeout: got 0 expected 1");
    end
    @(posedge clk); #1;
    rx_valid = 1'b0;
  endtask

  task automatic send_load(input logic [7:0] cnt, input int nw, input logic [7:0] chk, input bit stall);
    send_byte(cnt, stall);
    for (int w = 0; w < nw; w++) begin
      for (int i = 0; i < 4; i++) begin
        if (i == 3) exp_q.push_back({ADDR_W'(w), words[w]});
        send_byte(words[w][31-8*i -: 8], stall);
      end
    end
    send_byte(chk, stall);
  endtask

  task automatic do_start(input string nm);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check({nm, "_rx_ready"}, 32'(rx_ready), 32'd1);
    check({nm, "_proc_rst"}, 32'(proc_rst), 32'd1);
    check({nm, "_load_done"}, 32'(load_done), 32'd0);
    check({nm, "_err"}, 32'(err), 32'd0);
    check({nm, "_err_code"}, 32'(err_code), 32'd0);
  endtask

  initial begin
    logic [7:0] partial[5];
    partial[0] = 8'h12; partial[1] = 8'h34; partial[2] = 8'h56; partial[3] = 8'h78; partial[4] = 8'hA5;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_rx_ready", 32'(rx_ready), 32'd0);
    check("rst_im_we", 32'(im_we), 32'd0);
    check("rst_im_addr", 32'(im_addr), 32'd0);
    check("rst_im_wdata", im_wdata, 32'd0);
    check("rst_proc_rst", 32'(proc_rst), 32'd1);
    check("rst_load_done", 32'(load_done), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_err_code", 32'(err_code), 32'd0);
    sys_rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("idle_rx_ready", 32'(rx_ready), 32'd0);

    // Good load
    do_start("start1");
    words[0] = 32'h12345678;
    words[1] = 32'hA5A50F0F;
    send_load(8'h02, 2, 8'h0A, 1'b0);
    check("good_load_done", 32'(load_done), 32'd1);
    check("good_proc_rst", 32'(proc_rst), 32'd0);
    check("good_err", 32'(err), 32'd0);
    check("good_rx_ready", 32'(rx_ready), 32'd0);
    check("good_sb_empty", 32'(exp_q.size()), 32'd0);

    // Reload releases nothing until a new good load; then bad checksum
    do_start("reload1");
    send_load(8'h02, 2, 8'h0B, 1'b0);
    check("badchk_err", 32'(err), 32'd1);
    check("badchk_err_code", 32'(err_code), 32'd2);
    check("badchk_proc_rst", 32'(proc_rst), 32'd1);
    check("badchk_load_done", 32'(load_done), 32'd0);
    check("badchk_sb_empty", 32'(exp_q.size()), 32'd0);

    // Bad count 0x00
    do_start("start_cnt0");
    send_byte(8'h00, 1'b0);
    check("cnt0_err", 32'(err), 32'd1);
    check("cnt0_err_code", 32'(err_code), 32'd1);
    check("cnt0_rx_ready", 32'(rx_ready), 32'd0);
    check("cnt0_proc_rst", 32'(proc_rst), 32'd1);
    repeat (3) @(posedge clk);
    #1;

    // Bad count DEPTH+1
    do_start("start_cnt17");
    send_byte(8'h11, 1'b0);
    check("cnt17_err", 32'(err), 32'd1);
    check("cnt17_err_code", 32'(err_code), 32'd1);
    check("cnt17_rx_ready", 32'(rx_ready), 32'd0);
    repeat (3) @(posedge clk);
    #1;

    // Full depth with random stalls
    do_start("start_full");
    for (int k = 0; k < DEPTH; k++) words[k] = 32'(k);
    send_load(8'h10, DEPTH, 8'h10, 1'b1);
    check("full_load_done", 32'(load_done), 32'd1);
    check("full_proc_rst", 32'(proc_rst), 32'd0);
    check("full_sb_empty", 32'(exp_q.size()), 32'd0);

    // Reload with different data
    do_start("reload2");
    words[0] = 32'hDEADBEEF;
    send_load(8'h01, 1, 8'h23, 1'b0);
    check("reload_load_done", 32'(load_done), 32'd1);
    check("reload_proc_rst", 32'(proc_rst), 32'd0);

    // Reset mid-load after 5 data bytes
    do_start("start_midrst");
    words[0] = 32'h12345678;
    words[1] = 32'hA5A50F0F;
    send_byte(8'h02, 1'b0);
    for (int i = 0; i < 5; i++) begin
      if (i == 3) exp_q.push_back({ADDR_W'(0), words[0]});
      send_byte(partial[i], 1'b0);
    end
    sys_rst = 1'b1;
    #1;
    check("midrst_rx_ready", 32'(rx_ready), 32'd0);
    check("midrst_im_we", 32'(im_we), 32'd0);
    check("midrst_im_addr", 32'(im_addr), 32'd0);
    check("midrst_im_wdata", im_wdata, 32'd0);
    check("midrst_proc_rst", 32'(proc_rst), 32'd1);
    check("midrst_load_done", 32'(load_done), 32'd0);
    check("midrst_err", 32'(err), 32'd0);
    check("midrst_err_code", 32'(err_code), 32'd0);
    @(posedge clk); #1;
    sys_rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("midrst_idle_rx_ready", 32'(rx_ready), 32'd0);
    check("midrst_idle_proc_rst", 32'(proc_rst), 32'd1);
    do_start("start_after_rst");
    send_load(8'h02, 2, 8'h0A, 1'b0);
    check("after_rst_load_done", 32'(load_done), 32'd1);
    check("after_rst_proc_rst", 32'(proc_rst), 32'd0);

    repeat (3) @(posedge clk);
    #1;
    check("final_sb_empty", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
